// File: rtl/demux1_8_rr_sched_if.sv
// Valid/ready bundle for the 1:8 round-robin demux scheduler.
// slave = scheduler side, master = producer/consumer side.
interface demux1_8_rr_sched_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    sel;
  logic          burst_end;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  sel, burst_end
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output sel, burst_end
  );
endinterface

// File: rtl/demux1_8_rr_sched.sv
// Round-robin 1:8 demux scheduler with a one-word holding register.
// Each enabled channel takes BURST words before the grant rotates.
module demux1_8_rr_sched #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [7:0]           ch_mask,
  demux1_8_rr_sched_if.slave   bus
);

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] data_q;
  logic [2:0]    sel_q;
  logic [2:0]    ptr_q;
  logic [2:0]    ptr_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          be_q;
  logic          be_d;
  logic          live_q;

  logic [2:0]    tgt;
  logic [2:0]    nxt;
  logic [2:0]    idx;
  logic          hit;
  logic          hit2;
  logic [3:0]    eff;
  logic          last;
  logic          hold;
  logic          drain;
  logic          acc;

  assign hold  = state_q == HOLD_FULL;
  assign drain = hold && bus.out_ready[sel_q];
  // live_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = live_q && en && (|ch_mask)
                      && (!hold || drain);
  assign acc = bus.in_valid && bus.in_ready;

  always_comb begin
    tgt  = ptr_q;
    nxt  = '0;
    idx  = '0;
    hit  = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!hit && ch_mask[idx]) begin
        tgt = idx;
        hit = 1'b1;
      end
    end
    nxt = tgt;
    for (int i = 1; i < 8; i++) begin
      idx = tgt + 3'(i);
      if (!hit2 && ch_mask[idx]) begin
        nxt  = idx;
        hit2 = 1'b1;
      end
    end
  end

  // a masked-off ptr restarts the burst on the new channel
  assign eff  = (tgt == ptr_q) ? cnt_q : 4'd0;
  assign last = eff == 4'(BURST - 1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    be_d    = 1'b0;
    unique case (state_q)
      HOLD_EMPTY: if (acc) state_d = HOLD_FULL;
      HOLD_FULL:  if (drain && !acc) state_d = HOLD_EMPTY;
      default:    state_d = HOLD_EMPTY;
    endcase
    unique case (1'b1)
      acc && last: begin
        ptr_d = nxt;
        cnt_d = 4'd0;
        be_d  = 1'b1;
      end
      acc && !last: begin
        ptr_d = tgt;
        cnt_d = eff + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      be_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      live_q  <= 1'b1;
      if (acc) begin
        data_q <= bus.in_data;
        sel_q  <= tgt;
      end
    end
  end

  assign bus.out_valid = hold ? (8'd1 << sel_q) : 8'd0;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.burst_end = be_q;

endmodule

// File: tb/tb_demux1_8_rr_sched.sv
// Scoreboard bench: unit 0 runs BURST=4, unit 1 runs BURST=1.
// A spec-level model predicts routing; a monitor checks every cycle.
module tb_demux1_8_rr_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en0, en1;
  logic [7:0] m0, m1;

  demux1_8_rr_sched_if #(.DW(8)) b0 ();
  demux1_8_rr_sched_if #(.DW(8)) b1 ();

  demux1_8_rr_sched #(.DW(8), .BURST(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0),
    .ch_mask(m0), .bus(b0)
  );

  demux1_8_rr_sched #(.DW(8), .BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1),
    .ch_mask(m1), .bus(b1)
  );

  typedef struct {
    logic [7:0] d;
    int         ch;
  } exp_t;

  typedef struct {
    logic       vld;
    logic       rdy;
    logic [7:0] din;
    logic [7:0] ov;
    logic [7:0] orr;
    logic [7:0] dout;
    logic [2:0] sel;
    logic       be;
    logic       en;
    logic [7:0] m;
  } snap_t;

  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   ptr_m[2];
  int   cnt_m[2];
  bit   be_x[2];
  bit   up = 1'b0;
  int   seq0[$];
  int   seq1[$];
  bit   rec0 = 1'b0;
  bit   rec1 = 1'b0;

  function automatic void chk(string n,
                              logic [31:0] a,
                              logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               n, a, e, $time);
    end
  endfunction

  function automatic snap_t snap(int u);
    snap_t s;
    if (u == 0) begin
      s = '{b0.in_valid, b0.in_ready, b0.in_data,
            b0.out_valid, b0.out_ready, b0.out_data,
            b0.sel, b0.burst_end, en0, m0};
    end else begin
      s = '{b1.in_valid, b1.in_ready, b1.in_data,
            b1.out_valid, b1.out_ready, b1.out_data,
            b1.sel, b1.burst_end, en1, m1};
    end
    return s;
  endfunction

  function automatic void flush();
    q0.delete();
    q1.delete();
    ptr_m = '{0, 0};
    cnt_m = '{0, 0};
    be_x  = '{0, 0};
  endfunction

  // monitor: compares outputs against the head of the scoreboard
  task automatic mon(int u);
    snap_t      s;
    exp_t       f;
    bit         held;
    logic [7:0] xov;
    bit         xrdy;
    s = snap(u);
    f = '{d: 8'h0, ch: 0};
    held = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (held) f = (u == 0) ? q0[0] : q1[0];
    chk($sformatf("u%0d burst_end", u), 32'(s.be), 32'(be_x[u]));
    xov = held ? (8'd1 << f.ch) : 8'd0;
    chk($sformatf("u%0d out_valid", u), 32'(s.ov), 32'(xov));
    if (held) begin
      chk($sformatf("u%0d out_data", u), 32'(s.dout), 32'(f.d));
      chk($sformatf("u%0d sel", u), 32'(s.sel), f.ch);
    end
    xrdy = up && s.en && (s.m != 0) && (!held || s.orr[f.ch]);
    chk($sformatf("u%0d in_ready", u), 32'(s.rdy), 32'(xrdy));
    if (held && s.orr[f.ch]) begin
      if (u == 0) begin
        void'(q0.pop_front());
        if (rec0) seq0.push_back(f.ch);
      end else begin
        void'(q1.pop_front());
        if (rec1) seq1.push_back(f.ch);
      end
    end
  endtask

  // reference model: applies the routing rules on each accept
  task automatic mdl(int u);
    snap_t s;
    exp_t  e;
    int    p, c, t, np, b;
    bit    fd;
    s = snap(u);
    b = (u == 0) ? 4 : 1;
    p = ptr_m[u];
    c = cnt_m[u];
    be_x[u] = 1'b0;
    if (!(s.vld && s.rdy)) return;
    t = p;
    fd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!fd && s.m[(p + k) % 8]) begin
        t = (p + k) % 8;
        fd = 1'b1;
      end
    end
    if (t != p) c = 0;
    if (c == b - 1) begin
      np = t;
      fd = 1'b0;
      for (int k = 1; k < 8; k++) begin
        if (!fd && s.m[(t + k) % 8]) begin
          np = (t + k) % 8;
          fd = 1'b1;
        end
      end
      ptr_m[u] = np;
      cnt_m[u] = 0;
      be_x[u]  = 1'b1;
    end else begin
      ptr_m[u] = t;
      cnt_m[u] = c + 1;
    end
    e = '{d: s.din, ch: t};
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      mdl(0);
      mdl(1);
    end
  end

  task automatic setin(int u, bit v, logic [7:0] d);
    if (u == 0) begin
      b0.in_valid = v;
      b0.in_data  = d;
    end else begin
      b1.in_valid = v;
      b1.in_data  = d;
    end
  endtask

  task automatic setor(int u, logic [7:0] r);
    if (u == 0) b0.out_ready = r;
    else b1.out_ready = r;
  endtask

  task automatic send(int u, logic [7:0] d);
    bit ok;
    snap_t s;
    ok = 1'b0;
    setin(u, 1'b1, d);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      s = snap(u);
      if (s.rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL u%0d send timeout data=%0h", u, d);
    end
    @(posedge clk);
    #1;
    setin(u, 1'b0, d);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 up = 1'b1;
  endtask

  task automatic rnd(int u, int n);
    logic [7:0] mm;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      setin(u, $urandom_range(0, 3) != 0, 8'($urandom));
      setor(u, ($urandom_range(0, 3) == 0)
               ? 8'($urandom) : 8'hFF);
      mm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (u == 0) begin
        en0 = $urandom_range(0, 7) != 0;
        if ($urandom_range(0, 15) == 0) m0 = mm;
      end else begin
        en1 = $urandom_range(0, 7) != 0;
        if ($urandom_range(0, 15) == 0) m1 = mm;
      end
    end
  endtask

  task automatic chk_seq(string n, int got[$], int want[$]);
    chk({n, " count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", n, i), got[i], want[i]);
  endtask

  initial begin
    en0 = 1'b1;
    en1 = 1'b1;
    m0  = 8'hFF;
    m1  = 8'hA4;
    setin(0, 1'b0, 8'h0);
    setin(1, 1'b0, 8'h0);
    setor(0, 8'hFF);
    setor(1, 8'hFF);
    flush();
    #2;
    chk("rst out_valid", 32'(b0.out_valid), 0);
    chk("rst in_ready", 32'(b0.in_ready), 0);
    chk("rst out_data", 32'(b0.out_data), 0);
    chk("rst sel", 32'(b0.sel), 0);
    chk("rst burst_end", 32'(b0.burst_end), 0);
    release_rst();

    // sequential bursts over all channels
    rec0 = 1'b1;
    for (int i = 0; i < 32; i++) send(0, 8'(i));
    repeat (3) @(posedge clk);
    #1;
    rec0 = 1'b0;
    begin
      int w[$];
      for (int i = 0; i < 32; i++) w.push_back(i / 4);
      chk_seq("t1 sel", seq0, w);
    end
    seq0.delete();

    // BURST=1 over a sparse mask
    rec1 = 1'b1;
    for (int i = 0; i < 6; i++) send(1, 8'(8'h40 + i));
    repeat (3) @(posedge clk);
    #1;
    rec1 = 1'b0;
    chk_seq("t2 sel", seq1, '{2, 5, 7, 2, 5, 7});

    // back-pressure on channel 0
    m0 = 8'h01;
    setor(0, 8'hFE);
    send(0, 8'hA5);
    fork
      send(0, 8'h5A);
      begin
        repeat (5) @(posedge clk);
        #1 setor(0, 8'hFF);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // mask-off mid-burst
    rec0 = 1'b1;
    m0 = 8'h08;
    send(0, 8'h31);
    send(0, 8'h32);
    m0 = 8'hF0;
    for (int i = 0; i < 5; i++) send(0, 8'(8'h60 + i));
    repeat (3) @(posedge clk);
    #1;
    chk_seq("t4 sel", seq0, '{3, 3, 4, 4, 4, 4, 5});
    seq0.delete();

    // en low mid-burst
    m0 = 8'h02;
    send(0, 8'h71);
    send(0, 8'h72);
    en0 = 1'b0;
    m0 = 8'hFF;
    setin(0, 1'b1, 8'h73);
    repeat (10) @(posedge clk);
    #1 en0 = 1'b1;
    send(0, 8'h73);
    send(0, 8'h74);
    send(0, 8'h75);
    repeat (3) @(posedge clk);
    #1;
    chk_seq("t5 sel", seq0, '{1, 1, 1, 1, 2});
    seq0.delete();
    rec0 = 1'b0;

    // async reset while a word is held
    setor(0, 8'h00);
    send(0, 8'hC3);
    #2;
    rst_n = 1'b0;
    up = 1'b0;
    flush();
    #1;
    chk("t6 out_valid", 32'(b0.out_valid), 0);
    chk("t6 sel", 32'(b0.sel), 0);
    chk("t6 in_ready", 32'(b0.in_ready), 0);
    setor(0, 8'hFF);
    release_rst();
    rec0 = 1'b1;
    send(0, 8'h11);
    repeat (2) @(posedge clk);
    #1;
    rec0 = 1'b0;
    chk_seq("t6 first", seq0, '{0});
    seq0.delete();

    // randomized traffic on both units
    fork
      rnd(0, 400);
      rnd(1, 400);
    join
    #0;
    setin(0, 1'b0, 8'h0);
    setin(1, 1'b0, 8'h0);
    setor(0, 8'hFF);
    setor(1, 8'hFF);
    repeat (5) @(posedge clk);
    #1;
    chk("u0 sb empty", q0.size(), 0);
    chk("u1 sb empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1_8_rr_sched.md
Name: demux1_8_rr_sched

Overview:
Round-robin scheduler that distributes a single valid/ready input word stream across 8 output channels. It drives the select and the per-channel valid lines of a 1:8 demux stage. Each enabled channel receives BURST consecutive words before the grant rotates to the next enabled channel. A one-word output holding register keeps the block at full throughput under back-pressure.

Parameters:
DW, 8, data word width in bits
BURST, 4, words per channel grant; legal range 1..16

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  accept enable; when low, in_ready is 0 (a held word still drains)
ch_mask  in  8  per-channel enable; bit k=1 means channel k is eligible
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  DW  input word
out_valid  out  8  one-hot valid toward channel k; all zero when nothing is held
out_ready  in  8  per-channel ready
out_data  out  DW  held word, shared by all channels
sel  out  3  channel index of the held word (demux select)
burst_end  out  1  1-cycle pulse registered on the accept that completes a channel's burst

Behaviour:
- Reset (async assert, sync-released use): hold_valid=0, out_data=0, sel=0, ptr=0, cnt=0, burst_end=0. Hence out_valid=0 and in_ready=0 until the first edge after release.
- State: HOLD_EMPTY (hold_valid=0) and HOLD_FULL (hold_valid=1).
- out_valid = hold_valid ? (8'b1 << sel) : 8'b0. out_data = held word. Both are registered outputs.
- drain = hold_valid && out_ready[sel].
- target: ptr if ch_mask[ptr]=1; otherwise the first k with ch_mask[k]=1, searching ptr+1, ptr+2, ... mod 8.
- in_ready = en && (ch_mask != 0) && (!hold_valid || drain). This is combinational from out_ready and ch_mask; there is no combinational path from in_valid.
- On accept: hold_data<=in_data, sel<=target, hold_valid<=1. Latency is 1 cycle from input accept to out_valid.
- On drain with no accept: hold_valid<=0.
- On drain and accept in the same cycle: the new word replaces the old one, and hold_valid stays 1. This gives 1 word per cycle sustained throughput.
- Burst counting:
  - eff_cnt = (target==ptr) ? cnt : 0. A masked-off ptr starts a fresh burst on the new channel.
  - On accept with eff_cnt==BURST-1: cnt<=0, burst_end<=1, and ptr<=next enabled channel after target using the current ch_mask, wrapping 7->0. If target is the only enabled channel, ptr<=target.
  - On accept otherwise: ptr<=target, cnt<=eff_cnt+1, burst_end<=0.
  - With no accept: ptr and cnt hold, burst_end<=0.
- BURST=1: every accept advances ptr and pulses burst_end.
- ch_mask changes take effect on the next accept only. A held word is never re-routed, and sel is stable while hold_valid=1.
- ch_mask==0: no accepts. A held word still drains to its original sel.
- en low mid-burst: ptr and cnt are preserved, and the burst resumes when en returns high.
- rst_n asserted mid-transfer: the held word is discarded immediately and out_valid goes to 0 asynchronously.

Test Plan:
1. Reset, then ch_mask=8'hFF, BURST=4, all out_ready=1, 32 words with in_data=0..31 back-to-back. Expect words 0-3 on channel 0, 4-7 on channel 1, ..., 28-31 on channel 7; in_ready held at 1; burst_end pulses on the accepts of words 3, 7, ..., 31; first out_valid one cycle after the first accept.
2. ch_mask=8'b1010_0100, BURST=1, 6 words. Expect sel sequence 2,5,7,2,5,7 and out_valid one-hot matching.
3. Back-pressure: out_ready[0]=0 for 5 cycles while word A is held on channel 0. Expect out_valid=8'h01 and out_data=A stable, in_ready=0, no word lost. When out_ready[0] rises, A drains and the next word is accepted in the same cycle.
4. Mid-burst mask-off: BURST=4, 2 words accepted to channel 3, then ch_mask[3] cleared with channels 4-7 enabled. Expect the next word on channel 4 with cnt restarting, so 4 words go to channel 4.
5. en=0 after 2 words of a burst on channel 1 for 10 cycles. Expect in_ready=0, the held word drains, and after en=1 two more words go to channel 1 before rotating to channel 2.
6. Assert rst_n low while hold_valid=1 and between clock edges. Expect out_valid=0 and sel=0 immediately; after release, the first word goes to channel 0.
